datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Multi-cycle controller that drives the control inputs of the register-file/ALU/RAM datapath. It accepts one command per valid/ready handshake and decodes it into four operation types: ALU op, load, store and compare. It then sequences the register addresses, ALU_OP, wr_data_s, Write_Reg and Mem_Write strobes cycle by cycle, captures ZF/OF, and pulses Done. It sits between a command source (test harness or future instruction decoder) and the datapath.

Parameters:
LOAD_WAIT, 1, cycles spent in WAIT before a load write-back (RAM read settle); legal 0..7, 0 skips WAIT.

Ports:
clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-low reset
Cmd_Valid  input  1  command present
Cmd_Ready  output  1  sequencer can accept a command
Cmd_Op  input  2  00 ALU (rd=rs op rt), 01 load (rd=MEM[F[5:0]]), 10 store (MEM[F[5:0]]=rt), 11 compare (flags only)
Cmd_ALU_OP  input  3  ALU function code passed to datapath
Cmd_rs  input  5  source register A
Cmd_rt  input  5  source register B / store data register
Cmd_rd  input  5  destination register
ZF  input  1  datapath zero flag
OF  input  1  datapath overflow flag
rs  output  5  to datapath R_Addr_A
rt  output  5  to datapath R_Addr_B
rd  output  5  to datapath W_Addr
ALU_OP  output  3  to datapath ALU
wr_data_s  output  2  write-back select: 00 ALU result, 01 RAM data
Write_Reg  output  1  register-file write strobe
Mem_Write  output  1  RAM write strobe
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle completion pulse
Flag_Z  output  1  ZF captured by the last command
Flag_O  output  1  OF captured by the last command

Behaviour:
- Reset (Reset=0 at rising edge): state=IDLE. rs, rt, rd, ALU_OP, wr_data_s, Flag_Z and Flag_O are cleared to 0. Write_Reg, Mem_Write, Done and Busy are 0. Cmd_Ready is 1 from the first cycle after reset.
- Reset mid-command: abort at that edge. Strobes are low next cycle, no Done, no write occurs. Reset has priority over every other event.
- All outputs are registered or decoded from registered state only. There are no combinational paths from command inputs to outputs.
- States: IDLE, EXEC, WAIT, WRITE, DONE (one-hot or binary, implementer's choice).
- IDLE:
  - Cmd_Ready=1.
  - On Cmd_Valid=1, latch Cmd_Op, Cmd_ALU_OP, Cmd_rs, Cmd_rt and Cmd_rd, then go to EXEC.
  - rs, rt, rd and ALU_OP hold their last values while idle.
- EXEC (1 cycle):
  - rs, rt, rd and ALU_OP show the latched values. Strobes are 0. wr_data_s=01 for a load, otherwise 00.
  - At the exit edge, Flag_Z<=ZF and Flag_O<=OF.
  - Next state: op 00 or 10 -> WRITE. Op 01 -> WAIT if LOAD_WAIT>0, else WRITE. Op 11 -> DONE.
- WAIT (load only): counter loads LOAD_WAIT-1 on entry. Stay while counter!=0, decrementing each cycle, then go to WRITE. wr_data_s=01 throughout. Strobes are 0.
- WRITE (exactly 1 cycle):
  - Op 00: Write_Reg=1, wr_data_s=00.
  - Op 01: Write_Reg=1, wr_data_s=01.
  - Op 10: Mem_Write=1, Write_Reg=0.
  - Register writes with rd==0 are suppressed (Write_Reg stays 0); the command still completes.
  - Next state: DONE.
- DONE: Done=1 for exactly one cycle. Strobes are 0. Next state: IDLE.
- Cmd_Ready=0 in every non-IDLE state. Cmd_Valid is ignored there, with no queuing. The source must hold Cmd_Valid until it is accepted.
- Consecutive commands have at least one IDLE cycle between a Done and the next accept.
- Latency from the accept edge to Done high:
  - ALU and store: 3 cycles.
  - Compare: 2 cycles.
  - Load: 3+LOAD_WAIT cycles.
- Address and ALU outputs stay stable from EXEC through DONE for the whole command.
- Each command produces at most one Write_Reg or Mem_Write pulse. The two strobes are never high together.

Test Plan:
- Reset held low for 3 cycles with Cmd_Valid=1 -> all outputs 0 and no accept. After release: Cmd_Ready=1 and Busy=0.
- ALU op: Cmd_Op=00, rs=1, rt=2, rd=3, ALU_OP=3'b100 -> EXEC on cycle+1, Write_Reg=1 with wr_data_s=00 and rd=3 on cycle+2, Done on cycle+3. Mem_Write is never high.
- Load with LOAD_WAIT=1: Cmd_Op=01, rd=5 -> wr_data_s=01 from EXEC onward, one WAIT cycle, Write_Reg=1 on cycle+3, Done on cycle+4. With LOAD_WAIT=0, Done comes on cycle+3.
- Store: Cmd_Op=10, rt=7 -> Mem_Write=1 for exactly 1 cycle on cycle+2, Write_Reg=0 throughout. A second Cmd_Valid pulse while Busy is ignored, with Cmd_Ready=0.
- Compare: Cmd_Op=11 with datapath ZF=1, OF=0 -> Flag_Z=1, Flag_O=0 after EXEC, Done on cycle+2, no strobes. An ALU op with rd=0 -> Write_Reg stays 0 and Done still pulses.
- Reset driven low during the WRITE cycle of an ALU op -> at the next edge Write_Reg=0, Done stays 0, state is IDLE, flags are cleared.

Source files
------------

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: accepts one command per Cmd_Valid/Cmd_Ready handshake and sequences rs/rt/rd/ALU_OP/wr_data_s/Write_Reg/Mem_Write into the datapath, capturing ZF/OF and pulsing Done
module datapath_sequencer #(
  parameter int LOAD_WAIT = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [1:0] Cmd_Op,
  input  logic [2:0] Cmd_ALU_OP,
  input  logic [4:0] Cmd_rs,
  input  logic [4:0] Cmd_rt,
  input  logic [4:0] Cmd_rd,
  input  logic       ZF,
  input  logic       OF,
  output logic [4:0] rs,
  output logic [4:0] rt,
  output logic [4:0] rd,
  output logic [2:0] ALU_OP,
  output logic [1:0] wr_data_s,
  output logic       Write_Reg,
  output logic       Mem_Write,
  output logic       Busy,
  output logic       Done,
  output logic       Flag_Z,
  output logic       Flag_O
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EXEC = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] WAIT_INIT = 3'(LOAD_WAIT > 0 ? LOAD_WAIT - 1 : 0);
  logic [2:0] state, next, cnt;
  logic [1:0] op;
  always_comb
    next = state == IDLE  ? (Cmd_Valid ? EXEC : IDLE) :
           state == EXEC  ? (op == 2'b11 ? DONE : (op == 2'b01 && LOAD_WAIT > 0) ? WAIT : WRITE) :
           state == WAIT  ? (cnt == 3'd0 ? WRITE : WAIT) :
           state == WRITE ? DONE : IDLE;
  always_ff @(posedge clk)
    if (!Reset) begin
      state <= IDLE;
      op <= 2'b00;
      cnt <= 3'd0;
      rs <= 5'd0;
      rt <= 5'd0;
      rd <= 5'd0;
      ALU_OP <= 3'd0;
      wr_data_s <= 2'b00;
      Flag_Z <= 1'b0;
      Flag_O <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && Cmd_Valid) begin
        op <= Cmd_Op;
        ALU_OP <= Cmd_ALU_OP;
        rs <= Cmd_rs;
        rt <= Cmd_rt;
        rd <= Cmd_rd;
        wr_data_s <= Cmd_Op == 2'b01 ? 2'b01 : 2'b00;
      end
      if (state == EXEC) begin
        Flag_Z <= ZF;
        Flag_O <= OF;
        cnt <= WAIT_INIT;
      end
      if (state == WAIT)
        cnt <= cnt - 3'd1;
    end
  assign Cmd_Ready = state == IDLE;
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  assign Write_Reg = state == WRITE && !op[1] && rd != 5'd0;
  assign Mem_Write = state == WRITE && op == 2'b10;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: randomized scoreboard bench for datapath_sequencer
module tb_datapath_sequencer;
  localparam int LW = 1;
  logic clk = 0, Reset = 0, Cmd_Valid = 0, v0 = 0, ZF = 0, OF = 0;
  logic [1:0] Cmd_Op = 0;
  logic [2:0] Cmd_ALU_OP = 0;
  logic [4:0] Cmd_rs = 0, Cmd_rt = 0, Cmd_rd = 0;
  logic Cmd_Ready, Write_Reg, Mem_Write, Busy, Done, Flag_Z, Flag_O;
  logic [4:0] rs, rt, rd;
  logic [2:0] ALU_OP;
  logic [1:0] wr_data_s;
  logic r0, wr0, mw0, b0, d0, fz0, fo0;
  logic [4:0] rs0, rt0, rd0;
  logic [2:0] alu0;
  logic [1:0] wds0;

  datapath_sequencer #(.LOAD_WAIT(LW)) dut (
    .clk(clk), .Reset(Reset), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Op(Cmd_Op), .Cmd_ALU_OP(Cmd_ALU_OP), .Cmd_rs(Cmd_rs), .Cmd_rt(Cmd_rt), .Cmd_rd(Cmd_rd),
    .ZF(ZF), .OF(OF), .rs(rs), .rt(rt), .rd(rd), .ALU_OP(ALU_OP), .wr_data_s(wr_data_s),
    .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .Busy(Busy), .Done(Done),
    .Flag_Z(Flag_Z), .Flag_O(Flag_O)
  );

  datapath_sequencer #(.LOAD_WAIT(0)) u0 (
    .clk(clk), .Reset(Reset), .Cmd_Valid(v0), .Cmd_Ready(r0),
    .Cmd_Op(Cmd_Op), .Cmd_ALU_OP(Cmd_ALU_OP), .Cmd_rs(Cmd_rs), .Cmd_rt(Cmd_rt), .Cmd_rd(Cmd_rd),
    .ZF(ZF), .OF(OF), .rs(rs0), .rt(rt0), .rd(rd0), .ALU_OP(alu0), .wr_data_s(wds0),
    .Write_Reg(wr0), .Mem_Write(mw0), .Busy(b0), .Done(d0),
    .Flag_Z(fz0), .Flag_O(fo0)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] op;
    logic [2:0] alu;
    logic [4:0] rs, rt, rd;
    logic z, o;
    int acc;
  } cmd_t;
  cmd_t q[$];
  cmd_t cur;
  int errors = 0, checks = 0;
  bit mon_en = 0;
  int wr_n = 0, mw_n = 0;
  bit addr_bad = 0, was_busy = 0, was_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Latency from the accept cycle to the cycle Done is high.
  function automatic int lat(input logic [1:0] op);
    return op == 2'b11 ? 2 : op == 2'b01 ? 3 + LW : 3;
  endfunction

  task automatic send(input logic [1:0] op, input logic [2:0] alu, input logic [4:0] a, b, d, input logic z, o);
    int t = 0;
    cmd_t c;
    @(negedge clk);
    Cmd_Valid = 1;
    Cmd_Op = op;
    Cmd_ALU_OP = alu;
    Cmd_rs = a;
    Cmd_rt = b;
    Cmd_rd = d;
    while (!Cmd_Ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!Cmd_Ready) begin
      chk("accept_timeout", 0, 1);
      Cmd_Valid = 0;
      return;
    end
    // Flags change only once the previous command has finished, so they hold through this EXEC.
    ZF = z;
    OF = o;
    c = '{op, alu, a, b, d, z, o, cyc};
    q.push_back(c);
    @(negedge clk);
    Cmd_Valid = 0;
  endtask

  always @(negedge clk) if (mon_en) begin
    if (was_done) chk("idle_after_done", Busy, 0);
    if (Write_Reg || Mem_Write) chk("strobe_exclusive", Write_Reg & Mem_Write, 0);
    if (!Busy && (Write_Reg || Mem_Write || Done)) chk("idle_strobe", 1, 0);
    if (Busy) begin
      if (q.size() == 0) chk("busy_without_cmd", 0, 1);
      else begin
        cur = q[0];
        if ({rs, rt, rd, ALU_OP} !== {cur.rs, cur.rt, cur.rd, cur.alu}) addr_bad = 1;
        if (!was_busy) chk("wr_data_s_exec", wr_data_s, cur.op == 2'b01 ? 1 : 0);
        if (Write_Reg) chk("wr_data_s_write", wr_data_s, cur.op == 2'b01 ? 1 : 0);
        wr_n += Write_Reg ? 1 : 0;
        mw_n += Mem_Write ? 1 : 0;
        if (Done) begin
          chk("latency", cyc - cur.acc, lat(cur.op));
          chk("reg_writes", wr_n, (cur.op[1] == 1'b0 && cur.rd != 0) ? 1 : 0);
          chk("mem_writes", mw_n, cur.op == 2'b10 ? 1 : 0);
          chk("flag_z", Flag_Z, cur.z);
          chk("flag_o", Flag_O, cur.o);
          chk("addr_stable", addr_bad, 0);
          void'(q.pop_front());
          wr_n = 0;
          mw_n = 0;
          addr_bad = 0;
        end
      end
    end
    was_busy = Busy;
    was_done = Done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Cmd_Valid = 1;
    Cmd_Op = 2'b00;
    Cmd_rd = 5'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_strobes", {Write_Reg, Mem_Write}, 0);
      chk("rst_addr", {rs, rt, rd, ALU_OP, wr_data_s}, 0);
      chk("rst_flags", {Flag_Z, Flag_O}, 0);
    end
    Cmd_Valid = 0;
    Reset = 1;
    @(negedge clk);
    chk("post_rst_ready", Cmd_Ready, 1);
    chk("post_rst_busy", Busy, 0);
    mon_en = 1;
    send(2'b00, 3'b100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    send(2'b10, 3'b000, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1);
    send(2'b11, 3'b010, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
    send(2'b00, 3'b001, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0);
    send(2'b01, 3'b000, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(2'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
           $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("drain", q.size(), 0);
    @(negedge clk);
    mon_en = 0;
    // Abort an ALU op with reset asserted in its WRITE cycle.
    Cmd_Valid = 1;
    Cmd_Op = 2'b00;
    Cmd_rs = 5'd4;
    Cmd_rd = 5'd9;
    ZF = 1;
    OF = 1;
    @(negedge clk);
    Cmd_Valid = 0;
    @(negedge clk);
    chk("pre_rst_write", Write_Reg, 1);
    chk("pre_rst_flags", {Flag_Z, Flag_O}, 3);
    Reset = 0;
    @(negedge clk);
    chk("abort_write", Write_Reg, 0);
    chk("abort_done", Done, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_flags", {Flag_Z, Flag_O}, 0);
    chk("abort_addr", {rs, rd}, 0);
    Reset = 1;
    @(negedge clk);
    chk("abort_done_after", Done, 0);
    // LOAD_WAIT=0 instance: load completes without a WAIT cycle.
    v0 = 1;
    Cmd_Op = 2'b01;
    Cmd_rd = 5'd5;
    chk("lw0_ready", r0, 1);
    @(negedge clk);
    v0 = 0;
    chk("lw0_wds_exec", wds0, 1);
    chk("lw0_exec_write", wr0, 0);
    @(negedge clk);
    chk("lw0_write", wr0, 1);
    chk("lw0_write_wds", wds0, 1);
    @(negedge clk);
    chk("lw0_done", d0, 1);
    @(negedge clk);
    chk("lw0_idle", b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
